// File: rtl/switch_bounce_gen.sv
// Emulated bouncy switch: on a request, move sw_out to a new level, add LFSR-timed glitches, settle, pulse done.
// Latency: first sw_out edge 1 clock after accept; done exactly SETTLE clocks after the final edge.
// Backpressure: req/level are only sampled in IDLE; requests while busy are dropped, not queued.
`timescale 1ns/1ps
module switch_bounce_gen #(
    parameter int          BOUNCE_EDGES = 6,
    parameter int          GLITCH_BITS  = 5,
    parameter int          SETTLE       = 150,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic level,
    output logic sw_out,
    output logic busy,
    output logic done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BOUNCE,
        ST_SETTLE,
        ST_DONE
    } state_t;

    // An all-zero Galois LFSR would lock up, so a zero seed is replaced.
    localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] TAPS      = 16'hB400;
    localparam logic [15:0] SETTLE_M1 = 16'(SETTLE - 1);
    localparam logic [3:0]  EDGES     = 4'(BOUNCE_EDGES);

    state_t                 state_q, state_d;
    logic                   sw_q, sw_d;
    logic                   level_q, level_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic [15:0]            timer_q, timer_d;
    logic [3:0]             edges_q, edges_d;
    logic [GLITCH_BITS:0]   w;

    // Glitch hold width 1..2^GLITCH_BITS from the current LFSR low bits.
    assign w      = {1'b0, lfsr_q[GLITCH_BITS-1:0]} + {{GLITCH_BITS{1'b0}}, 1'b1};
    // LFSR free-runs every clock regardless of state.
    assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);

    // Next-state and datapath updates for the bounce sequencer.
    always_comb begin
        state_d = state_q;
        sw_d    = sw_q;
        level_d = level_q;
        timer_d = timer_q;
        edges_d = edges_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (level == sw_q) begin
                        state_d = ST_DONE;
                    end else begin
                        level_d = level;
                        sw_d    = level;
                        if (BOUNCE_EDGES > 0) begin
                            edges_d = EDGES;
                            timer_d = 16'(w);
                            state_d = ST_BOUNCE;
                        end else begin
                            timer_d = SETTLE_M1;
                            state_d = ST_SETTLE;
                        end
                    end
                end
            end
            ST_BOUNCE: begin
                if (timer_q == 16'd1) begin
                    sw_d = ~sw_q;
                    if (edges_q > 4'd1) begin
                        edges_d = edges_q - 4'd1;
                        timer_d = 16'(w);
                    end else begin
                        // Even glitch count: this last toggle lands back on level_q.
                        edges_d = 4'd0;
                        timer_d = SETTLE_M1;
                        state_d = ST_SETTLE;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            ST_SETTLE: begin
                sw_d = level_q;
                if (timer_q == 16'd0) begin
                    state_d = ST_DONE;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers; reset aborts any sequence and forces sw_out low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            sw_q    <= 1'b0;
            level_q <= 1'b0;
            lfsr_q  <= SEED_EFF;
            timer_q <= 16'd0;
            edges_q <= 4'd0;
        end else begin
            state_q <= state_d;
            sw_q    <= sw_d;
            level_q <= level_d;
            lfsr_q  <= lfsr_d;
            timer_q <= timer_d;
            edges_q <= edges_d;
        end
    end

    assign sw_out = sw_q;
    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_switch_bounce_gen.sv
// Bench for switch_bounce_gen: schedule-based reference model plus directed scenarios.
// Latency: model predicts every sw_out/busy/done value per cycle from the LFSR edge schedule.
// Backpressure: requests issued while busy are expected to be dropped.
`timescale 1ns/1ps
module tb_switch_bounce_gen;

    localparam int          BE   = 6;
    localparam int          GB   = 5;
    localparam int          ST   = 150;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic req = 1'b0;
    logic level = 1'b0;
    logic sw_out;
    logic busy;
    logic done;

    always #5 clk = ~clk;

    switch_bounce_gen #(
        .BOUNCE_EDGES(BE),
        .GLITCH_BITS (GB),
        .SETTLE      (ST),
        .LFSR_SEED   (SEED)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .level (level),
        .sw_out(sw_out),
        .busy  (busy),
        .done  (done)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic int wof(input logic [15:0] v);
        return (int'(v) % (1 << GB)) + 1;
    endfunction

    // Reference model: on accept, lay out the whole edge schedule and done time.
    int          mcyc = 0;
    logic [15:0] m_lfsr = SEED;
    logic        m_sw = 1'b0, m_busy = 1'b0, m_done = 1'b0;
    int          done_t = -1;
    int          tog_q[$];

    initial begin
        logic [15:0] cur, v;
        int t, w;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                mcyc = 0; m_lfsr = SEED; m_sw = 1'b0; m_busy = 1'b0; m_done = 1'b0;
                done_t = -1; tog_q.delete();
            end else begin
                mcyc++;
                cur = m_lfsr;
                m_lfsr = step(cur);
                if (!m_busy && req) begin
                    if (level == m_sw) begin
                        done_t = mcyc;
                    end else begin
                        m_sw = level;
                        t = mcyc;
                        v = cur;
                        for (int i = 0; i < BE; i++) begin
                            w = wof(v);
                            for (int k = 0; k < w; k++) v = step(v);
                            t += w;
                            tog_q.push_back(t);
                        end
                        done_t = t + ST;
                    end
                end
                if (tog_q.size() > 0 && tog_q[0] == mcyc) begin
                    m_sw = ~m_sw;
                    void'(tog_q.pop_front());
                end
                m_busy = (mcyc <= done_t);
                m_done = (mcyc == done_t);
            end
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("sw_out", int'(sw_out), int'(m_sw));
            check("busy",   int'(busy),   int'(m_busy));
            check("done",   int'(done),   int'(m_done));
        end
    end

    // Edge / done timestamp monitor.
    int   edges[$];
    int   done_cyc = -1;
    logic prev_sw = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (sw_out !== prev_sw) edges.push_back(mcyc);
                prev_sw = sw_out;
                if (done) done_cyc = mcyc;
            end else begin
                prev_sw = 1'b0;
            end
        end
    end

    // Downstream debouncer: follows sw_out only after 100 stable differing cycles.
    logic deb = 1'b0;
    int   deb_cnt = 0;
    int   deb_chg = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                deb = 1'b0; deb_cnt = 0;
            end else if (sw_out != deb) begin
                deb_cnt++;
                if (deb_cnt >= 100) begin
                    deb = sw_out; deb_cnt = 0; deb_chg++;
                end
            end else begin
                deb_cnt = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int acc;

    task automatic start_req(input logic lvl);
        req = 1'b1; level = lvl; acc = mcyc + 1;
        tick(1);
        req = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, " done_timeout"}, int'(done), 1);
    endtask

    task automatic check_seq(input string name, input int n_edges, input logic fin);
        check({name, " edge_count"}, edges.size(), n_edges);
        check({name, " final_sw"}, int'(sw_out), int'(fin));
        if (edges.size() > 0) begin
            check({name, " settle"}, done_cyc - edges[edges.size()-1], ST);
            for (int i = 1; i < edges.size(); i++) begin
                check({name, " interval_range"},
                      int'(edges[i] - edges[i-1] >= 1 && edges[i] - edges[i-1] <= (1 << GB)), 1);
            end
        end
    endtask

    initial begin
        int d0, a_done, n;
        // Pin the model's LFSR and width arithmetic to hand-computed values.
        check("lfsr step1", int'(step(SEED)), 16'hE270);
        check("lfsr step2", int'(step(step(SEED))), 16'h7138);
        check("w seed", wof(SEED), 2);
        check("w step2", wof(step(step(SEED))), 25);

        // Reset then idle.
        rst = 1'b0;
        tick(3);
        check("reset sw_out", int'(sw_out), 0);
        check("reset busy", int'(busy), 0);
        rst = 1'b1;
        tick(50);
        check("idle edges", edges.size(), 0);

        // Rising request with defaults.
        edges.delete(); d0 = deb_chg;
        start_req(1'b1);
        wait_done("rise");
        tick(1);
        check_seq("rise", 7, 1'b1);
        check("rise first_edge", edges.size() > 0 ? edges[0] : -1, acc);
        check("rise deb_changes", deb_chg - d0, 1);
        check("rise deb_level", int'(deb), 1);

        // No-change request.
        edges.delete();
        start_req(1'b1);
        wait_done("nochg");
        tick(1);
        check("nochg done_cycle", done_cyc, acc);
        check("nochg edges", edges.size(), 0);

        // Ignore while busy, then re-trigger with req held into IDLE.
        edges.delete(); d0 = deb_chg;
        start_req(1'b0);
        tick(2);
        req = 1'b1; level = 1'b1;
        tick(1);
        req = 1'b0;
        n = 0;
        while (edges.size() < 7 && n < 400) begin tick(1); n++; end
        check("ignore edges_timeout", int'(edges.size() >= 7), 1);
        tick(50);
        req = 1'b1; level = 1'b1;
        tick(1);
        req = 1'b0;
        tick(5);
        req = 1'b1; level = 1'b1;
        wait_done("ignore");
        tick(1);
        check_seq("ignore", 7, 1'b0);
        a_done = done_cyc;
        edges.delete();
        tick(2);
        req = 1'b0;
        wait_done("retrig");
        tick(1);
        check_seq("retrig", 7, 1'b1);
        check("retrig first_edge", edges.size() > 0 ? edges[0] : -1, a_done + 2);
        check("retrig deb_changes", deb_chg - d0, 2);

        // Reset mid-sequence, then reproduce timing from the seed.
        rst = 1'b0;
        tick(3);
        rst = 1'b1; req = 1'b1; level = 1'b1;
        edges.delete();
        tick(1);
        req = 1'b0;
        tick(1);
        check("pre_reset sw_out", int'(sw_out), 1);
        rst = 1'b0;
        #1;
        check("async sw_out", int'(sw_out), 0);
        check("async busy", int'(busy), 0);
        tick(3);
        rst = 1'b1; req = 1'b1; level = 1'b1;
        edges.delete();
        tick(1);
        req = 1'b0;
        wait_done("rerun");
        tick(1);
        check_seq("rerun", 7, 1'b1);
        check("rerun interval1", edges.size() > 1 ? edges[1] - edges[0] : -1, 2);
        check("rerun interval2", edges.size() > 2 ? edges[2] - edges[1] : -1, 25);

        tick(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/switch_bounce_gen.md
Name: switch_bounce_gen

Overview:
Generates a mechanical-switch bounce waveform on a single output. It is the stimulus end of our switch debounce path and is used on-board and in benches to exercise the debouncers. On a request it moves sw_out to a new level and then adds a burst of pseudo-random glitch toggles, timed by an LFSR. It then holds the level stable for a settle window and pulses done.

Parameters:
BOUNCE_EDGES, 6, number of glitch toggles after the initial edge; must be even, range 0..14
GLITCH_BITS, 5, glitch hold width is 1..2^GLITCH_BITS cycles; range 1..8
SETTLE, 150, cycles sw_out is held stable before done; must be at least 1 and fit in 16 bits; must exceed the debouncer calming window of 100
LFSR_SEED, 16'hACE1, initial LFSR value; a zero value is replaced by 16'h0001

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
req  input  1  start request; sampled only in IDLE
level  input  1  target switch level; latched when req is accepted
sw_out  output  1  emulated bouncy switch signal (registered)
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the sequence completes

Behaviour:
- Reset (async, rst=0): state=IDLE, sw_out=0, busy=0, done=0, lfsr=LFSR_SEED, timer=0, edges_left=0, level_q=0. Reset mid-sequence aborts it immediately, and sw_out drops to 0 asynchronously.
- LFSR: 16-bit Galois, taps mask 16'hB400, shifts right every clock in every state. w = lfsr[GLITCH_BITS-1:0] + 1, computed GLITCH_BITS+1 bits wide, giving a range of 1..2^GLITCH_BITS.
- States: IDLE, BOUNCE, SETTLE, DONE.
- IDLE, req=1 and level==sw_out: go to DONE. sw_out is unchanged and there are no edges.
- IDLE, req=1 and level!=sw_out:
  - latch level_q=level and set sw_out=level.
  - if BOUNCE_EDGES>0: edges_left=BOUNCE_EDGES, timer=w, go to BOUNCE.
  - if BOUNCE_EDGES==0: timer=SETTLE-1, go to SETTLE.
- IDLE, req=0: stay in IDLE.
- BOUNCE:
  - timer decrements each cycle; expiry is timer==1.
  - on expiry with edges_left>1: toggle sw_out, edges_left--, timer=w.
  - on expiry with edges_left==1: toggle sw_out, which now equals level_q by even parity; timer=SETTLE-1, go to SETTLE.
- SETTLE: sw_out is held at level_q. If timer==0, go to DONE; otherwise timer decrements.
- DONE: done=1 and busy=1 for exactly one cycle, then go to IDLE with busy=0.
- Timing:
  - every interval between consecutive sw_out edges within one sequence is w cycles, where w is in 1..2^GLITCH_BITS.
  - done rises exactly SETTLE clocks after the final sw_out edge.
  - accept-to-first-edge latency is 1 clock, since sw_out is registered.
- Concurrency and level tracking:
  - req and level are ignored while busy, including in DONE. A req held high re-triggers on the first cycle back in IDLE.
  - a change of level during a sequence has no effect, because level_q is used.
- Outputs done, busy and sw_out are all registered from state and counters; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, then rst=1 with req=0 for 50 cycles -> sw_out=0, busy=0, done=0 throughout, with no edges.
- Rising request with defaults: req=1, level=1 for one cycle -> sw_out rises 1 clock later. Exactly 7 sw_out edges occur, each interval is 1..32 cycles, and the final value is 1. done rises exactly 150 clocks after the 7th edge and lasts 1 cycle; busy falls with done. The intervals match a reference model of the 0xB400 Galois LFSR seeded 0xACE1.
- No-change request: after completing level=1, pulse req with level=1 -> done high on the next clock, busy high for exactly 1 cycle, sw_out has 0 edges.
- Ignore while busy: start level=0 from sw_out=1, then assert req with level=1 mid-BOUNCE and mid-SETTLE -> the sequence completes at 0 with 7 edges. The req is not queued; it re-triggers only when held into IDLE.
- Reset mid-sequence: assert rst=0 during BOUNCE -> sw_out=0 and busy=0 asynchronously. After release the LFSR restarts from 0xACE1 and a new req reproduces the identical edge timing.
- Downstream check with BOUNCE_EDGES=6, GLITCH_BITS=5, SETTLE=150 driving a debouncer -> the debounced output changes exactly once per request and never follows a glitch.
